// File: rtl/sn_window_writer.sv
// sn_window_writer
// Writer side of the Sn sample RAM. It takes one NSAM-sample speech frame over
// a valid/ready stream, multiplies each sample by its analysis-window
// coefficient (signed-magnitude Q16), writes the result to Sn RAM address i,
// and raises donewr once the whole frame is in RAM.
//
// Build option:
//   SN_WINDOW_SAT_EN  defined   -> an overflowing product saturates its magnitude
//                     undefined -> an overflowing product keeps the low N-1 bits (wrap)
// In both builds the sticky ovf flag records the overflow.
module sn_window_writer #(
    parameter int N    = 32,
    parameter int Q    = 16,
    parameter int NSAM = 320,
    parameter int AW   = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          startwr,
    input  logic          in_valid,
    input  logic [N-1:0]  in_sample,
    output logic          in_ready,
    output logic [AW-1:0] win_addr,
    input  logic [N-1:0]  win_data,
    output logic [AW-1:0] sn_wr_addr,
    output logic [N-1:0]  sn_wr_data,
    output logic          sn_wr_en,
    output logic          ovf,
    output logic          donewr
);

    typedef enum logic [3:0] {
        ST_START       = 4'd0,
        ST_WAIT_SAMPLE = 4'd1,
        ST_WAIT_ROM    = 4'd2,
        ST_LATCH       = 4'd3,
        ST_CALC        = 4'd4,
        ST_WRITE       = 4'd5,
        ST_INCR        = 4'd6,
        ST_CHECK       = 4'd7,
        ST_DONE        = 4'd8
    } state_t;

    localparam logic [AW-1:0] NSAM_C = AW'(NSAM);
    localparam logic [AW-1:0] ONE_C  = {{(AW-1){1'b0}}, 1'b1};

    // Signed-magnitude fixed-point multiply, same semantics as the shared
    // multiplier. Returns {overflow, result}. The magnitude product is formed
    // at full 2(N-1) width so that overflow can be seen above the kept field.
    // A zero magnitude never carries a sign, so there is no negative zero.
    function automatic logic [N:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*(N-1)-1:0] full_v;
        logic [N-2:0]       mag_v;
        logic               ovf_v;
        logic               sign_v;
        full_v = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
        ovf_v  = |(full_v >> (N - 1 + Q));
`ifdef SN_WINDOW_SAT_EN
        if (ovf_v) begin
            mag_v = {(N-1){1'b1}};
        end else begin
            mag_v = (N-1)'(full_v >> Q);
        end
`else
        mag_v = (N-1)'(full_v >> Q);
`endif
        if (mag_v == {(N-1){1'b0}}) begin
            sign_v = 1'b0;
        end else begin
            sign_v = a[N-1] ^ b[N-1];
        end
        return {ovf_v, sign_v, mag_v};
    endfunction

    state_t        state_r;
    state_t        next_state_s;
    logic [AW-1:0] i_r;
    logic [N-1:0]  sample_r;
    logic [N-1:0]  in_a_r;
    logic [N-1:0]  in_b_r;
    logic [N-1:0]  prod_r;
    logic [N:0]    mul_s;
    logic          in_ready_r;
    logic [AW-1:0] win_addr_r;
    logic [AW-1:0] sn_wr_addr_r;
    logic          sn_wr_en_r;
    logic          ovf_r;
    logic          donewr_r;

    assign mul_s      = sm_mul(in_a_r, in_b_r);
    assign in_ready   = in_ready_r;
    assign win_addr   = win_addr_r;
    assign sn_wr_addr = sn_wr_addr_r;
    assign sn_wr_data = prod_r;
    assign sn_wr_en   = sn_wr_en_r;
    assign ovf        = ovf_r;
    assign donewr     = donewr_r;

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_START;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: one sample walks accept -> ROM -> latch -> multiply ->
    // write -> increment -> check before the next sample is taken.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_START: begin
                if (startwr) begin
                    next_state_s = ST_WAIT_SAMPLE;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_WAIT_SAMPLE: begin
                if (in_valid && in_ready_r) begin
                    next_state_s = ST_WAIT_ROM;
                end else begin
                    next_state_s = ST_WAIT_SAMPLE;
                end
            end
            ST_WAIT_ROM: next_state_s = ST_LATCH;
            ST_LATCH:    next_state_s = ST_CALC;
            ST_CALC:     next_state_s = ST_WRITE;
            ST_WRITE:    next_state_s = ST_INCR;
            ST_INCR:     next_state_s = ST_CHECK;
            ST_CHECK: begin
                if (i_r < NSAM_C) begin
                    next_state_s = ST_WAIT_SAMPLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                // A frame only restarts after startwr has been low for a cycle.
                if (startwr) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_START;
                end
            end
            default: next_state_s = ST_START;
        endcase
    end

    // Datapath and registered outputs. Status outputs are loaded from the
    // next state so they are high exactly while in their state; the write
    // address/data are loaded on leaving CALC so that they and the strobe are
    // all valid during the WRITE cycle (4 clocks after the accept cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_r          <= {AW{1'b0}};
            sample_r     <= {N{1'b0}};
            in_a_r       <= {N{1'b0}};
            in_b_r       <= {N{1'b0}};
            prod_r       <= {N{1'b0}};
            in_ready_r   <= 1'b0;
            win_addr_r   <= {AW{1'b0}};
            sn_wr_addr_r <= {AW{1'b0}};
            sn_wr_en_r   <= 1'b0;
            ovf_r        <= 1'b0;
            donewr_r     <= 1'b0;
        end else begin
            in_ready_r <= (next_state_s == ST_WAIT_SAMPLE);
            sn_wr_en_r <= (next_state_s == ST_WRITE);
            donewr_r   <= (next_state_s == ST_DONE);
            case (state_r)
                ST_START: begin
                    i_r   <= {AW{1'b0}};
                    ovf_r <= 1'b0;
                end
                ST_WAIT_SAMPLE: begin
                    if (in_valid && in_ready_r) begin
                        sample_r   <= in_sample;
                        win_addr_r <= i_r;
                    end
                end
                ST_LATCH: begin
                    in_a_r <= sample_r;
                    in_b_r <= win_data;
                end
                ST_CALC: begin
                    prod_r       <= mul_s[N-1:0];
                    sn_wr_addr_r <= i_r;
                    ovf_r        <= ovf_r | mul_s[N];
                end
                ST_INCR: begin
                    i_r <= i_r + ONE_C;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_window_writer.sv
// tb_sn_window_writer
// Directed bench for sn_window_writer with a registered window-ROM model.
// Honours SN_WINDOW_SAT_EN for the expected overflow result.
module tb_sn_window_writer;

    localparam int N    = 32;
    localparam int AW   = 9;
    localparam int NSAM = 320;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          startwr = 1'b0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_sample = 32'd0;
    logic          in_ready;
    logic [AW-1:0] win_addr;
    logic [N-1:0]  win_data;
    logic [AW-1:0] sn_wr_addr;
    logic [N-1:0]  sn_wr_data;
    logic          sn_wr_en;
    logic          ovf;
    logic          donewr;

    logic [N-1:0]  rom   [0:(1<<AW)-1];
    logic [N-1:0]  frame [0:NSAM-1];
    logic [N-1:0]  dir_tab [0:3];
    logic          exp_ovf;
    int            n_total = 0;
    int            n_bad   = 0;

    sn_window_writer dut (
        .clk        (clk),
        .rst        (rst),
        .startwr    (startwr),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .in_ready   (in_ready),
        .win_addr   (win_addr),
        .win_data   (win_data),
        .sn_wr_addr (sn_wr_addr),
        .sn_wr_data (sn_wr_data),
        .sn_wr_en   (sn_wr_en),
        .ovf        (ovf),
        .donewr     (donewr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Registered window ROM: data valid one cycle after the address.
    always @(posedge clk) win_data <= rom[win_addr];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference multiply built on plain 64-bit arithmetic: {overflow, result}.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod_v;
        logic [63:0] shr_v;
        logic [30:0] mag_v;
        logic        o_v;
        prod_v = {33'd0, a[30:0]} * {33'd0, b[30:0]};
        shr_v  = prod_v >> 16;
        o_v    = (shr_v > 64'h0000_0000_7FFF_FFFF);
`ifdef SN_WINDOW_SAT_EN
        mag_v  = o_v ? 31'h7FFF_FFFF : shr_v[30:0];
`else
        mag_v  = shr_v[30:0];
`endif
        if (mag_v == 31'd0) return {o_v, 32'd0};
        else return {o_v, a[31] ^ b[31], mag_v};
    endfunction

    task automatic check_reset();
        check_val("rst_in_ready",   {63'd0, in_ready},   64'd0);
        check_val("rst_sn_wr_en",   {63'd0, sn_wr_en},   64'd0);
        check_val("rst_sn_wr_addr", {55'd0, sn_wr_addr}, 64'd0);
        check_val("rst_sn_wr_data", {32'd0, sn_wr_data}, 64'd0);
        check_val("rst_win_addr",   {55'd0, win_addr},   64'd0);
        check_val("rst_ovf",        {63'd0, ovf},        64'd0);
        check_val("rst_donewr",     {63'd0, donewr},     64'd0);
    endtask

    // Random frame, magnitudes below 2^30 so coefficients up to 2.0 never overflow.
    task automatic fill_frame();
        logic [31:0] r_v;
        logic [31:0] s_v;
        for (int k = 0; k < NSAM; k++) begin
            r_v = $urandom;
            s_v = $urandom_range(0, 1);
            frame[k] = {s_v[0], 1'b0, r_v[29:0]};
        end
    endtask

    // Feed n samples of frame[]; for each one check the write that follows.
    task automatic drive_frame(input int n, input bit gaps, input bit cont, input int drop_at, input bit dir);
        int          t;
        int          stray;
        logic        rdy;
        logic [3:0]  pat;
        logic [32:0] m_v;
        logic [31:0] exp_d;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid  = 1'b1;
            in_sample = frame[k];
            t = 0;
            rdy = 1'b0;
            stray = 0;
            while (!rdy && t < 64) begin
                @(negedge clk);
                rdy = in_ready;
                if (sn_wr_en) stray++;
                t++;
            end
            check_val("stray_wr", 64'(stray), 64'd0);
            if (!rdy) begin
                check_val("accept_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            if (cont && k > 0) check_val("accept_gap", 64'(4 + t), 64'd7);
            @(posedge clk);
            #1;
            if (k == drop_at) startwr = 1'b0;
            if (cont && (k + 1) < n) begin
                in_sample = frame[k + 1];
            end else begin
                in_valid = 1'b0;
            end
            pat = 4'd0;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                pat = {sn_wr_en, pat[3:1]};
            end
            m_v = ref_mul(frame[k], rom[k]);
            exp_ovf = exp_ovf | m_v[32];
            exp_d = (dir && k < 4) ? dir_tab[k] : m_v[31:0];
            check_val("wr_en_timing", {60'd0, pat},        64'h8);
            check_val("wr_addr",      {55'd0, sn_wr_addr}, 64'(k));
            check_val("win_addr",     {55'd0, win_addr},   64'(k));
            check_val("wr_data",      {32'd0, sn_wr_data}, {32'd0, exp_d});
            check_val("ovf",          {63'd0, ovf},        {63'd0, exp_ovf});
        end
    endtask

    task automatic wait_done();
        bit seen;
        int stray;
        seen = 1'b0;
        stray = 0;
        for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            if (sn_wr_en) stray++;
            if (donewr) seen = 1'b1;
        end
        check_val("donewr_set", {63'd0, seen}, 64'd1);
        check_val("done_stray_wr", 64'(stray), 64'd0);
    endtask

    initial begin
        logic [31:0] r_v;
        logic [31:0] s_v;
        bit          hold_ok;

        for (int a = 0; a < (1 << AW); a++) begin
            r_v = $urandom_range(0, 32'h0001_0000);
            s_v = $urandom_range(0, 1);
            rom[a] = {s_v[0], r_v[30:0]};
        end
        rom[0] = 32'h0000_8000;
        rom[1] = 32'h0001_0000;
        rom[2] = 32'h0000_0001;
        rom[3] = 32'h0002_0000;
        dir_tab[0] = 32'h0000_8000;
        dir_tab[1] = 32'h8001_8000;
        dir_tab[2] = 32'h0000_0000;
`ifdef SN_WINDOW_SAT_EN
        dir_tab[3] = 32'h7FFF_FFFF;
`else
        dir_tab[3] = 32'h7FFE_0000;
`endif

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1 rst = 1'b1;

        // Frame 1: directed head, random tail, random valid gaps.
        fill_frame();
        frame[0] = 32'h0001_0000;
        frame[1] = 32'h8001_8000;
        frame[2] = 32'h8000_0001;
        frame[3] = 32'h7FFF_0000;
        exp_ovf = 1'b0;
        startwr = 1'b1;
        drive_frame(NSAM, 1'b1, 1'b0, -1, 1'b1);
        wait_done();

        // startwr held high: no restart, donewr stays up, offered sample ignored.
        in_valid  = 1'b1;
        in_sample = 32'h0001_0000;
        hold_ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (!donewr || in_ready || sn_wr_en) hold_ok = 1'b0;
        end
        check_val("hold_no_restart", {63'd0, hold_ok}, 64'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1 startwr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("donewr_clear", {63'd0, donewr},   64'd0);
        check_val("idle_ready",   {63'd0, in_ready}, 64'd0);

        // Frame 2: overflow early, then asynchronous reset after sample 100.
        fill_frame();
        frame[3] = 32'h7FFF_0000;
        exp_ovf = 1'b0;
        @(posedge clk);
        #1 startwr = 1'b1;
        drive_frame(101, 1'b1, 1'b0, -1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset();
        startwr  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Frame 3: in_valid held high, startwr dropped mid-frame.
        fill_frame();
        exp_ovf = 1'b0;
        startwr = 1'b1;
        drive_frame(NSAM, 1'b0, 1'b1, 10, 1'b0);
        wait_done();
        @(negedge clk);
        check_val("donewr_pulse", {63'd0, donewr}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sn_window_writer.md
Name: sn_window_writer

Overview:
- Writer side of the Sn sample RAM that the autocorrelation block reads. Accepts one 320-sample speech frame over a valid/ready stream and multiplies each sample by its analysis-window coefficient. Writes each windowed result to Sn RAM address i, then flags frame-complete so the autocorrelation stage can start.
- All arithmetic is signed-magnitude Q format: N=32 bits, with 1 sign bit, 15 integer bits and Q=16 fraction bits.

Parameters:
- N, 32, word width of samples, coefficients and RAM data.
- Q, 16, number of fraction bits.
- NSAM, 320, samples per frame, which is also the number of RAM words written.
- AW, 9, address width for the Sn RAM and the window ROM.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- startwr  input  1  frame start request; level-sensitive.
- in_valid  input  1  in_sample is valid.
- in_sample  input  N  speech sample, signed-magnitude Q16.
- in_ready  output  1  block can accept a sample this cycle.
- win_addr  output  AW  window ROM address.
- win_data  input  N  window coefficient; registered ROM, valid 1 cycle after win_addr.
- sn_wr_addr  output  AW  Sn RAM write address.
- sn_wr_data  output  N  Sn RAM write data.
- sn_wr_en  output  1  Sn RAM write strobe; one-cycle pulse.
- ovf  output  1  sticky overflow flag for the current frame.
- donewr  output  1  frame fully written.

Behaviour:
- Reset (rst low, asynchronous): STATE=START, i=0, in_ready=0, sn_wr_en=0, sn_wr_addr=0, sn_wr_data=0, win_addr=0, ovf=0, donewr=0.
  - Reset mid-frame aborts immediately. RAM words already written are left as they are; there is no rollback.
- State machine, registered STATE/NEXT_STATE, with the output/datapath always block separate:
  - START: i<=0, ovf<=0. Go to WAIT_SAMPLE if startwr=1, else stay.
  - WAIT_SAMPLE: in_ready=1 (registered; high exactly while in this state).
    - On in_valid&&in_ready: capture in_sample into sample_r, win_addr<=i, go to WAIT_ROM.
    - Otherwise stay; there is no timeout.
  - WAIT_ROM: in_ready=0; wait 1 cycle for ROM data. Go to LATCH.
  - LATCH: in_a<=sample_r, in_b<=win_data. Go to CALC.
  - CALC: register the multiplier result into prod_r and set ovf if this multiply overflowed. Go to WRITE.
  - WRITE: sn_wr_addr<=i, sn_wr_data<=prod_r, sn_wr_en<=1 for exactly one cycle. Go to INCR.
  - INCR: sn_wr_en<=0, i<=i+1. Go to CHECK.
  - CHECK: go to WAIT_SAMPLE if i<NSAM, else DONE.
  - DONE: donewr<=1. Stay while startwr=1. When startwr=0, clear donewr and return to START.
- Throughput: at most one sample per 7 cycles (accept cycle through CHECK). Upstream must tolerate in_ready low.
- Latency: the accept cycle is followed by exactly 4 clocks, and sn_wr_en is high during the 4th of them.
- Write order: addresses 0..NSAM-1 strictly ascending; each written exactly once per frame.
- Multiply (same semantics as the team's fixed-point multiplier):
  - sign = a[N-1] XOR b[N-1].
  - magnitude = (a[N-2:0]*b[N-2:0]) >> Q, using a 2(N-1)-bit full product.
  - If the magnitude is 0, the result sign is forced to 0 (no negative zero).
  - Overflow: any nonzero product bit above bit N-2+Q. This sets ovf; behaviour then follows the Optional Feature.
- Boundaries:
  - in_valid while not in WAIT_SAMPLE: ignored, sample not consumed.
  - startwr held high after DONE: no new frame starts until startwr drops for at least one cycle.
  - startwr dropped mid-frame: ignored; the frame completes.
  - Last sample (i=NSAM-1): written, then i=NSAM → DONE. i never wraps.

Optional Feature:
- Macro SN_WINDOW_SAT_EN.
  - Defined: on overflow the magnitude saturates to all ones (2^(N-1)-1) with the computed sign.
  - Undefined: on overflow the magnitude is the low N-1 bits of the shifted product (wrap).
- ovf is set in both builds.

Test Plan:
- Reset then startwr=1, sample 0x00010000 (1.0), win 0x00008000 (0.5) → write addr 0, data 0x00008000, sn_wr_en 1 cycle, 4 clocks after accept.
- Sample 0x80018000 (-1.5), win 0x00010000 → data 0x80018000. Sample 0x80000001, win 0x00000001 → data 0x00000000 (sign cleared).
- Sample 0x7FFF0000, win 0x00020000 → ovf=1; data 0x7FFFFFFF with SN_WINDOW_SAT_EN, 0x7FFE0000 without.
- Full frame of 320 samples with random in_valid gaps → addresses 0..319 in order, no duplicates, donewr=1 after the last write; donewr clears after startwr=0.
- Reset asserted after sample 100 → all outputs at reset values immediately. A new frame restarts at addr 0 with ovf=0.
- in_valid held high continuously → exactly one accept per 7 cycles; no sample is lost or duplicated.
